// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if
//   Groups the control and status signals of the programmable clock divider.
//   The clock (CLKIN) and reset (ACLR_L) are not part of the interface.
//
//   Signals:
//     EN          count enable
//     DIV_LOAD    one-cycle request to load DIV_IN as the pending divisor
//     DIV_IN      requested divisor N
//     CLKOUT      divided clock, period N CLKIN cycles
//     TICK        one-cycle strobe per CLKOUT period
//     DIV_ACTIVE  divisor currently in effect
//     PENDING     a loaded divisor is waiting for the next period boundary
//     DIV_ERR     sticky flag: last load was 0 or 1
//
//   Modports:
//     master  drives the controls and observes the status (user side)
//     slave   the divider itself
interface clk_div_prog_if #(
    parameter int CNT_W = 16
);
    logic             EN;
    logic             DIV_LOAD;
    logic [CNT_W-1:0] DIV_IN;
    logic             CLKOUT;
    logic             TICK;
    logic [CNT_W-1:0] DIV_ACTIVE;
    logic             PENDING;
    logic             DIV_ERR;

    modport master (
        output EN, DIV_LOAD, DIV_IN,
        input  CLKOUT, TICK, DIV_ACTIVE, PENDING, DIV_ERR
    );

    modport slave (
        input  EN, DIV_LOAD, DIV_IN,
        output CLKOUT, TICK, DIV_ACTIVE, PENDING, DIV_ERR
    );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog
//   Runtime-programmable integer clock divider. Produces a divided square
//   wave (low for ceil(N/2) cycles, then high for floor(N/2) cycles) and a
//   one-cycle TICK strobe during the last cycle of each period. A newly
//   loaded divisor is held pending and only takes effect at a period
//   boundary, so CLKOUT never shows a runt pulse.
//
//   Parameters:
//     CNT_W    width of the period counter and of the divisor
//     DEF_DIV  divisor in effect after reset (2 .. 2^CNT_W-1)
//
//   Ports:
//     CLKIN    system clock, rising-edge
//     ACLR_L   asynchronous active-low reset
//     bus      clk_div_prog_if.slave (EN, DIV_LOAD, DIV_IN in;
//              CLKOUT, TICK, DIV_ACTIVE, PENDING, DIV_ERR out)
module clk_div_prog #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 100
) (
    input  logic                 CLKIN,
    input  logic                 ACLR_L,
    clk_div_prog_if.slave        bus
);

    localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);

    generate
        if (DEF_DIV < 2 || longint'(DEF_DIV) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_def_div
            $error("clk_div_prog: DEF_DIV out of range 2 .. 2^CNT_W-1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             clkout_reg, clkout_next;
    logic             tick_reg, tick_next;
    logic [CNT_W-1:0] div_active_reg, div_active_next;
    logic [CNT_W-1:0] div_pend_reg, div_pend_next;
    logic             pending_reg, pending_next;
    logic             div_err_reg, div_err_next;

    // Low-phase length ceil(N/2) for the divisor in force after this edge.
    // One extra bit so N = 2^CNT_W-1 does not overflow on the +1.
    logic [CNT_W:0]   half_next;
    logic             wrap;

    assign wrap = (cnt_reg == div_active_reg - CNT_W'(1));

    always_comb begin
        cnt_next        = cnt_reg;
        clkout_next     = clkout_reg;
        tick_next       = 1'b0;
        div_active_next = div_active_reg;
        div_pend_next   = div_pend_reg;
        pending_next    = pending_reg;
        div_err_next    = div_err_reg;
        half_next       = '0;

        if (bus.EN) begin
            if (wrap) begin
                cnt_next = '0;
                // Apply only the value that was pending before this edge;
                // a load on this same edge is handled below and stays pending.
                if (pending_reg) begin
                    div_active_next = div_pend_reg;
                    pending_next    = 1'b0;
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
            // Outputs are derived from the next-state count so they line up
            // with cnt without an extra cycle of latency.
            half_next   = ({1'b0, div_active_next} + (CNT_W+1)'(1)) >> 1;
            clkout_next = ({1'b0, cnt_next} >= half_next);
            tick_next   = (cnt_next == div_active_next - CNT_W'(1));
        end

        // Loads are accepted even while counting is disabled; last one wins.
        if (bus.DIV_LOAD) begin
            pending_next = 1'b1;
            if (bus.DIV_IN < CNT_W'(2)) begin
                div_pend_next = CNT_W'(2);
                div_err_next  = 1'b1;
            end else begin
                div_pend_next = bus.DIV_IN;
                div_err_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLKIN or negedge ACLR_L) begin
        if (!ACLR_L) begin
            cnt_reg        <= '0;
            clkout_reg     <= 1'b0;
            tick_reg       <= 1'b0;
            div_active_reg <= DEF_DIV_V;
            div_pend_reg   <= DEF_DIV_V;
            pending_reg    <= 1'b0;
            div_err_reg    <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            clkout_reg     <= clkout_next;
            tick_reg       <= tick_next;
            div_active_reg <= div_active_next;
            div_pend_reg   <= div_pend_next;
            pending_reg    <= pending_next;
            div_err_reg    <= div_err_next;
        end
    end

    assign bus.CLKOUT     = clkout_reg;
    assign bus.TICK       = tick_reg;
    assign bus.DIV_ACTIVE = div_active_reg;
    assign bus.PENDING    = pending_reg;
    assign bus.DIV_ERR    = div_err_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog
//   Segment table of {reset, EN, load, DIV_IN, cycles} with the expected
//   CLKOUT-high count, TICK count and end-of-segment status, plus a
//   per-cycle scoreboard fed by a small behavioural model and a few
//   hand-written TICK-spacing and asynchronous-reset checks.
module tb_clk_div_prog;

    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 100;

    logic CLKIN  = 1'b0;
    logic ACLR_L = 1'b0;

    clk_div_prog_if #(.CNT_W(CNT_W)) bus ();

    clk_div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .CLKIN  (CLKIN),
        .ACLR_L (ACLR_L),
        .bus    (bus.slave)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct packed {
        logic             clkout;
        logic             tick;
        logic [CNT_W-1:0] div_active;
        logic             pending;
        logic             div_err;
    } obs_t;

    typedef struct {
        bit    arst;
        bit    en;
        bit    ld;
        int    din;
        int    cycles;
        int    exp_hi;
        int    exp_tk;
        int    exp_div;
        bit    exp_pend;
        bit    exp_err;
        string tag;
    } seg_t;

    seg_t tbl[$];
    obs_t exp_q[$];
    int   tick_edges[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   edge_no = 0;

    // Behavioural model state
    int m_cnt, m_n, m_pend;
    bit m_pending, m_err, m_clk, m_tick;

    function automatic void model_reset();
        m_cnt = 0; m_n = DEF_DIV; m_pend = DEF_DIV;
        m_pending = 0; m_err = 0; m_clk = 0; m_tick = 0;
    endfunction

    function automatic void model_edge(bit en, bit ld, int din);
        bit was_pending = m_pending;
        if (en) begin
            if (m_cnt == m_n - 1) begin
                m_cnt = 0;
                if (was_pending) begin
                    m_n = m_pend;
                    m_pending = 0;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_clk  = (m_cnt >= (m_n + 1) / 2);
            m_tick = (m_cnt == m_n - 1);
        end else begin
            m_tick = 0;
        end
        if (ld) begin
            m_pend    = (din < 2) ? 2 : din;
            m_pending = 1;
            m_err     = (din < 2);
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.clkout     = m_clk;
        o.tick       = m_tick;
        o.div_active = CNT_W'(m_n);
        o.pending    = m_pending;
        o.div_err    = m_err;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_obs(input string tag);
        obs_t e, a;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty at edge %0d", tag, edge_no);
            return;
        end
        e = exp_q.pop_front();
        a.clkout     = bus.CLKOUT;
        a.tick       = bus.TICK;
        a.div_active = bus.DIV_ACTIVE;
        a.pending    = bus.PENDING;
        a.div_err    = bus.DIV_ERR;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s edge %0d: got clk=%0b tick=%0b div=%0d pend=%0b err=%0b, expected clk=%0b tick=%0b div=%0d pend=%0b err=%0b",
                     tag, edge_no, a.clkout, a.tick, a.div_active, a.pending, a.div_err,
                     e.clkout, e.tick, e.div_active, e.pending, e.div_err);
        end
    endtask

    // One CLKIN edge: inputs are already stable, model and expectation are
    // produced at the edge, the DUT is sampled 1 time unit later.
    task automatic step(input bit en, input bit ld, input int din, input string tag);
        bus.EN       = en;
        bus.DIV_LOAD = ld;
        bus.DIV_IN   = CNT_W'(din);
        @(posedge CLKIN);
        edge_no++;
        model_edge(en, ld, din);
        exp_q.push_back(model_obs());
        #1;
        check_obs(tag);
        if (bus.TICK === 1'b1) tick_edges.push_back(edge_no);
        bus.DIV_LOAD = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_clkout"},  32'(bus.CLKOUT), 0);
        chk({tag, "_tick"},    32'(bus.TICK), 0);
        chk({tag, "_div"},     32'(bus.DIV_ACTIVE), DEF_DIV);
        chk({tag, "_pending"}, 32'(bus.PENDING), 0);
        chk({tag, "_err"},     32'(bus.DIV_ERR), 0);
    endtask

    // Reset asserted mid-cycle: outputs must clear without waiting for a
    // clock edge, then stay cleared across edges until release.
    task automatic do_async_reset();
        #2 ACLR_L = 1'b0;
        #1;
        check_reset_values("arst_now");
        model_reset();
        repeat (2) @(posedge CLKIN);
        #1;
        check_reset_values("arst_hold");
        ACLR_L = 1'b1;
        edge_no = 0;
        tick_edges.delete();
    endtask

    task automatic add_seg(input bit arst, input bit en, input bit ld, input int din,
                           input int cycles, input int hi, input int tk, input int dv,
                           input bit pend, input bit err, input string tag);
        seg_t s;
        s.arst = arst; s.en = en; s.ld = ld; s.din = din; s.cycles = cycles;
        s.exp_hi = hi; s.exp_tk = tk; s.exp_div = dv; s.exp_pend = pend;
        s.exp_err = err; s.tag = tag;
        tbl.push_back(s);
    endtask

    function automatic int last_gap();
        int n = tick_edges.size();
        if (n < 2) return -1;
        return tick_edges[n-1] - tick_edges[n-2];
    endfunction

    initial begin
        int hi, tk;

        //       arst en ld din  cyc  hi tk  div  pnd err
        add_seg(0, 1, 0,   0, 100, 50, 1, 100, 0, 0, "default_100");
        add_seg(0, 1, 0,   0,  20,  0, 0, 100, 0, 0, "run_to_cnt20");
        add_seg(0, 1, 1,   7,   1,  0, 0, 100, 1, 0, "load_7");
        add_seg(0, 1, 0,   0,  79, 50, 1,   7, 0, 0, "finish_100_apply_7");
        add_seg(0, 1, 0,   0,  14,  6, 2,   7, 0, 0, "div_7");
        add_seg(0, 1, 1,   9,   1,  0, 0,   7, 1, 0, "load_9");
        add_seg(0, 1, 0,   0,   4,  2, 0,   7, 1, 0, "div_7_mid");
        add_seg(0, 1, 0,   0,   1,  1, 1,   7, 1, 0, "div_7_last");
        add_seg(0, 1, 1,   4,   1,  0, 0,   9, 1, 0, "load_4_on_wrap");
        add_seg(0, 1, 0,   0,   9,  4, 1,   4, 0, 0, "div_9");
        add_seg(0, 1, 0,   0,   8,  4, 2,   4, 0, 0, "div_4");
        add_seg(0, 1, 1,   1,   1,  0, 0,   4, 1, 1, "load_1");
        add_seg(0, 1, 0,   0,   3,  2, 1,   2, 0, 1, "apply_clamped_2");
        add_seg(0, 1, 0,   0,   6,  3, 3,   2, 0, 1, "div_2");
        add_seg(0, 1, 1,   5,   1,  1, 1,   2, 1, 0, "load_5");
        add_seg(0, 1, 0,   0,   1,  0, 0,   5, 0, 0, "apply_5");
        add_seg(0, 1, 0,   0,  10,  4, 2,   5, 0, 0, "div_5");
        add_seg(0, 1, 1, 100,   1,  0, 0,   5, 1, 0, "load_100");
        add_seg(0, 1, 0,   0,   4,  2, 1, 100, 0, 0, "apply_100");
        add_seg(0, 1, 0,   0,  30,  0, 0, 100, 0, 0, "run_to_cnt30");
        add_seg(0, 0, 0,   0,  10,  0, 0, 100, 0, 0, "en_low_10");
        add_seg(0, 1, 0,   0,  70, 50, 1, 100, 0, 0, "resume_after_en");
        add_seg(0, 1, 0,   0,  99, 50, 1, 100, 0, 0, "run_to_last");
        add_seg(0, 0, 0,   0,   3,  3, 0, 100, 0, 0, "en_low_at_last");
        add_seg(0, 1, 0,   0,   1,  0, 0, 100, 0, 0, "wrap_after_hold");
        add_seg(0, 1, 0,   0,  59, 10, 0, 100, 0, 0, "run_to_cnt59");
        add_seg(0, 1, 1,  12,   1,  1, 0, 100, 1, 0, "load_12");
        add_seg(1, 1, 0,   0, 100, 50, 1, 100, 0, 0, "after_reset");

        bus.EN = 1'b0; bus.DIV_LOAD = 1'b0; bus.DIV_IN = '0;
        model_reset();
        repeat (3) @(posedge CLKIN);
        #1;
        check_reset_values("reset");
        ACLR_L = 1'b1;
        edge_no = 0;

        foreach (tbl[s]) begin
            if (tbl[s].arst) do_async_reset();
            hi = 0; tk = 0;
            for (int c = 0; c < tbl[s].cycles; c++) begin
                step(tbl[s].en, tbl[s].ld && (c == 0), tbl[s].din, tbl[s].tag);
                if (bus.CLKOUT === 1'b1) hi++;
                if (bus.TICK === 1'b1) tk++;
            end
            chk({tbl[s].tag, "_clkout_high"}, hi, tbl[s].exp_hi);
            chk({tbl[s].tag, "_ticks"},       tk, tbl[s].exp_tk);
            chk({tbl[s].tag, "_div_active"},  32'(bus.DIV_ACTIVE), tbl[s].exp_div);
            chk({tbl[s].tag, "_pending"},     32'(bus.PENDING), 32'(tbl[s].exp_pend));
            chk({tbl[s].tag, "_div_err"},     32'(bus.DIV_ERR), 32'(tbl[s].exp_err));
            $display("seg %0d %s: en=%0b ld=%0b din=%0d cycles=%0d high=%0d ticks=%0d div=%0d pend=%0b err=%0b",
                     s, tbl[s].tag, tbl[s].en, tbl[s].ld, tbl[s].din, tbl[s].cycles,
                     hi, tk, bus.DIV_ACTIVE, bus.PENDING, bus.DIV_ERR);

            // TICK spacing corner cases
            if (tbl[s].tag == "default_100" || tbl[s].tag == "after_reset")
                chk({tbl[s].tag, "_first_tick_edge"},
                    (tick_edges.size() > 0) ? tick_edges[0] : -1, 99);
            if (tbl[s].tag == "div_7")
                chk("div_7_tick_gap", last_gap(), 7);
            if (tbl[s].tag == "div_4")
                chk("div_4_tick_gap", last_gap(), 4);
            if (tbl[s].tag == "resume_after_en")
                chk("en_low_period_len", last_gap(), 110);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider that generates a divided square wave (CLKOUT) and a one-cycle period-boundary strobe (TICK) from CLKIN.
- Next-generation divider for the keyboard-reader timing path:
  - counter width is parametrised;
  - divisor is loadable at run time and applied glitch-free at period boundaries;
  - clock enable is supported.
- Serves scan-rate and sample-rate clock generation where the fixed divide-by-100 is insufficient.

Parameters:
- CNT_W, 16, width of the period counter and of the divisor.
- DEF_DIV, 100, divisor in effect after reset. Legal range is 2 .. 2^CNT_W-1; anything else is an elaboration error.

Ports:
- CLKIN  input  1  system clock; all state updates on its rising edge.
- ACLR_L  input  1  asynchronous active-low reset.
- EN  input  1  count enable. When low, all state holds.
- DIV_LOAD  input  1  one-cycle request to load DIV_IN as the pending divisor.
- DIV_IN  input  CNT_W  requested divisor N.
- CLKOUT  output  1  divided clock with period N CLKIN cycles (registered).
- TICK  output  1  high for exactly one CLKIN cycle per CLKOUT period (registered).
- DIV_ACTIVE  output  CNT_W  divisor currently in effect.
- PENDING  output  1  high while a loaded divisor is waiting to be applied.
- DIV_ERR  output  1  sticky flag: the last load was an illegal value (0 or 1).

Behaviour:
- Reset (ACLR_L=0, asynchronous):
  - cnt=0, CLKOUT=0, TICK=0, DIV_ACTIVE=DEF_DIV, pending register=DEF_DIV, PENDING=0, DIV_ERR=0.
- Counting, on each rising edge with EN=1:
  - if cnt==DIV_ACTIVE-1, cnt wraps to 0 (the "wrap edge");
  - otherwise cnt increments by 1.
  - Arithmetic is unsigned CNT_W-bit; cnt never exceeds DIV_ACTIVE-1.
- Output timing, with L = ceil(N/2):
  - CLKOUT is registered so that it is 0 while cnt<L and 1 while cnt>=L. It is computed from the next-state count, so there is no extra latency relative to cnt.
  - Result: low for ceil(N/2) cycles, then high for floor(N/2) cycles.
  - N=100 gives 50 low / 50 high, starting low after reset. N=3 gives 2 low / 1 high. N=2 gives 1 low / 1 high.
- TICK is registered and equals 1 exactly during the cycle where cnt==N-1. The first TICK after reset is high during the cycle following the (N-1)-th enabled edge.
- EN=0:
  - cnt, CLKOUT and DIV_ACTIVE hold; TICK is forced to 0.
  - A DIV_LOAD is still accepted into the pending register.
- Divisor load:
  - On an edge with DIV_LOAD=1, the pending register takes DIV_IN, PENDING goes to 1, and DIV_ERR takes (DIV_IN<2).
  - DIV_IN of 0 or 1 is clamped to 2 in the pending register.
  - A later DIV_LOAD before application overwrites the pending value (last wins).
- Application:
  - On a wrap edge with PENDING=1, DIV_ACTIVE takes the pending value and PENDING clears.
  - The new N governs the period starting at cnt=0.
  - A divisor is never applied mid-period, so there are no runt CLKOUT pulses.
- Simultaneous DIV_LOAD and wrap edge:
  - the wrap applies the pending value that existed before that edge (if PENDING was 1);
  - the newly loaded value becomes pending (PENDING=1) and is applied at the following wrap.
- DIV_ERR clears on the next load of a legal value (>=2).
- Reset mid-period or while PENDING=1 discards the pending divisor and returns to DEF_DIV immediately.

Test Plan:
- Reset release with EN=1, default DEF_DIV=100 -> CLKOUT 0 for 50 cycles, then 1 for 50; TICK pulses once every 100 cycles, first at cycle 100; DIV_ACTIVE=100.
- DIV_LOAD with DIV_IN=7 at cnt=20 -> PENDING=1; period stays 100 until the wrap, then 4 low / 3 high, TICK every 7 cycles; PENDING=0, DIV_ACTIVE=7.
- DIV_IN=9 then DIV_IN=4 loaded within one period, with the second load on the wrap edge -> next period uses 9; the period after uses 4 (2 low / 2 high).
- DIV_IN=1 loaded -> DIV_ERR=1, applied divisor 2 (1 low / 1 high); a later load of 5 clears DIV_ERR.
- EN low for 10 cycles at cnt=30 with N=100 -> CLKOUT holds 0, TICK stays 0; on EN high counting resumes, and that period is 110 CLKIN cycles long in total.
- ACLR_L asserted at cnt=60 with PENDING=1 (DIV_IN=12) -> immediately CLKOUT=0, TICK=0, PENDING=0, DIV_ACTIVE=100; after release the period is 100.
